// File: rtl/lfsr_rng.sv
// lfsr_rng: XNOR Fibonacci-style LFSR with a bounded random-number draw FSM.
// A draw rejects out-of-range LFSR values (0 or above MAX_VAL) by advancing
// the LFSR. It falls back to num=1 with err=1 after 2^WIDTH rejections.
// Optional feature: define LFSR_LOCKUP_RECOVER_EN so that any advance from
// the all-ones lockup state produces 0 and sets the sticky lockup_seen flag.
module lfsr_rng #(
  parameter int unsigned      WIDTH   = 6,
  parameter logic [WIDTH-1:0] TAPS    = 6'b110000,
  parameter int unsigned      MAX_VAL = 63
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  input  logic             ack,
  output logic [WIDTH-1:0] state_out,
  output logic [WIDTH-1:0] num,
  output logic             valid,
  output logic             busy,
  output logic             err,
  output logic             lockup_seen
);

  localparam logic [WIDTH:0]   ATT_LIMIT = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH-1:0] MAXV      = WIDTH'(MAX_VAL);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} fsm_t;

  fsm_t             fsm, fsm_nxt;
  logic [WIDTH-1:0] lfsr, lfsr_adv;
  logic [WIDTH:0]   att_cnt;
  logic             in_range;
  logic             draw_start, draw_accept, draw_reject, draw_fail;
  logic             adv;

  // Next LFSR value for one advance step
  always_comb begin
    lfsr_adv = {lfsr[WIDTH-2:0], ~^(lfsr & TAPS)};
`ifdef LFSR_LOCKUP_RECOVER_EN
    if (lfsr == '1) lfsr_adv = '0;
`endif
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm <= IDLE;
    else       fsm <= fsm_nxt;
  end

  // FSM next-state logic
  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (draw_start) fsm_nxt = DRAW;
      DRAW:    if (draw_accept || draw_fail) fsm_nxt = DONE;
      DONE:    if (ack) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  // FSM outputs and draw decisions; a load during DRAW freezes the draw for that cycle
  always_comb begin
    busy        = (fsm != IDLE);
    valid       = (fsm == DONE);
    in_range    = (lfsr != '0) && (lfsr <= MAXV);
    draw_start  = (fsm == IDLE) && req;
    draw_fail   = (fsm == DRAW) && !load && (att_cnt == ATT_LIMIT);
    draw_accept = (fsm == DRAW) && !load && (att_cnt != ATT_LIMIT) && in_range;
    draw_reject = (fsm == DRAW) && !load && (att_cnt != ATT_LIMIT) && !in_range;
    adv         = !load && (draw_accept || draw_reject || (en && (fsm != DRAW)));
  end

  // LFSR register: load beats any advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     lfsr <= '0;
    else if (load) lfsr <= seed_in;
    else if (adv)  lfsr <= lfsr_adv;
  end

  // Attempt counter, drawn number and error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      att_cnt <= '0;
      num     <= '0;
      err     <= 1'b0;
    end else begin
      if (draw_start) begin
        att_cnt <= '0;
        err     <= 1'b0;
      end
      if (draw_reject) att_cnt <= att_cnt + 1'b1;
      if (draw_accept) num <= lfsr;
      if (draw_fail) begin
        num <= WIDTH'(1);
        err <= 1'b1;
      end
    end
  end

`ifdef LFSR_LOCKUP_RECOVER_EN
  logic lockup_q;

  // Sticky flag set whenever an advance leaves the all-ones state
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    lockup_q <= 1'b0;
    else if (adv && lfsr == '1)   lockup_q <= 1'b1;
  end

  assign lockup_seen = lockup_q;
`else
  assign lockup_seen = 1'b0;
`endif

  assign state_out = lfsr;

endmodule

// File: tb/tb_lfsr_rng.sv
`timescale 1ns/1ps
module tb_lfsr_rng;
  localparam int W       = 6;
  localparam int TAPS_I  = 48;
  localparam int MAXV    = 10;
  localparam int LIMIT   = 64;
  localparam int PH_IDLE = 0;
  localparam int PH_DRAW = 1;
  localparam int PH_DONE = 2;
`ifdef LFSR_LOCKUP_RECOVER_EN
  localparam bit RECOVER = 1'b1;
`else
  localparam bit RECOVER = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, en, load, req, ack;
  logic [W-1:0] seed_in, state_out, num;
  logic         valid, busy, err, lockup_seen;

  lfsr_rng #(.WIDTH(W), .TAPS(6'b110000), .MAX_VAL(MAXV)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in),
    .req(req), .ack(ack), .state_out(state_out), .num(num), .valid(valid),
    .busy(busy), .err(err), .lockup_seen(lockup_seen)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_state, m_phase, m_cnt, m_num;
  bit m_err, m_lock;

  typedef struct {
    bit en, load, req, ack;
    int seed;
    int st, vld, nm, bsy, er;
  } vec_t;
  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Next LFSR value from the rule: shift left, feed back XNOR of tapped bits
  function automatic int ref_next(input int s);
    int ones;
    ones = $countones(s & TAPS_I);
    if (RECOVER && s == 63) return 0;
    return ((s * 2) % 64) + (((ones % 2) == 0) ? 1 : 0);
  endfunction

  task automatic model_reset();
    m_state = 0; m_phase = PH_IDLE; m_cnt = 0; m_num = 0; m_err = 0; m_lock = 0;
  endtask

  task automatic model_step();
    bit adv;
    int nphase;
    adv = 0;
    nphase = m_phase;
    case (m_phase)
      PH_IDLE: begin
        if (req) begin nphase = PH_DRAW; m_cnt = 0; m_err = 0; end
        adv = en;
      end
      PH_DRAW: begin
        if (!load) begin
          if (m_cnt == LIMIT) begin
            m_num = 1; m_err = 1; nphase = PH_DONE;
          end else if (m_state >= 1 && m_state <= MAXV) begin
            m_num = m_state; adv = 1; nphase = PH_DONE;
          end else begin
            adv = 1; m_cnt++;
          end
        end
      end
      default: begin
        adv = en;
        if (ack) nphase = PH_IDLE;
      end
    endcase
    if (load) m_state = seed_in;
    else if (adv) begin
      if (RECOVER && m_state == 63) m_lock = 1;
      m_state = ref_next(m_state);
    end
    m_phase = nphase;
  endtask

  task automatic cmp_all(input string tag);
    check({tag, ".state"}, state_out, m_state);
    check({tag, ".valid"}, valid, (m_phase == PH_DONE) ? 1 : 0);
    check({tag, ".busy"}, busy, (m_phase != PH_IDLE) ? 1 : 0);
    check({tag, ".num"}, num, m_num);
    check({tag, ".err"}, err, m_err);
    check({tag, ".lockup"}, lockup_seen, m_lock);
  endtask

  task automatic idle_inputs();
    en = 0; load = 0; req = 0; ack = 0; seed_in = '0;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    cmp_all(tag);
  endtask

  // Asynchronous reset between clock edges; outputs checked before any edge
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1;
    #1;
    model_reset();
    cmp_all(tag);
    idle_inputs();
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int first_zero;
    int distinct;
    bit seen[64];
    int exp_start[6];

    reset = 1;
    idle_inputs();
    #2;
    model_reset();
    cmp_all("por");
    @(negedge clk);
    reset = 0;

    // directed table: draw, hold, ack, load during DRAW, req during DONE
    tbl[0]  = '{0, 0, 1, 0, 0,  0,  0, 0, 1, 0};
    tbl[1]  = '{1, 0, 0, 0, 0,  1,  0, 0, 1, 0};
    tbl[2]  = '{0, 0, 0, 0, 0,  3,  1, 1, 1, 0};
    tbl[3]  = '{0, 0, 1, 0, 0,  3,  1, 1, 1, 0};
    tbl[4]  = '{0, 0, 0, 1, 0,  3,  0, 1, 0, 0};
    tbl[5]  = '{0, 1, 0, 1, 5,  5,  0, 1, 0, 0};
    tbl[6]  = '{0, 0, 1, 0, 0,  5,  0, 1, 1, 0};
    tbl[7]  = '{0, 1, 0, 0, 12, 12, 0, 1, 1, 0};
    tbl[8]  = '{0, 1, 0, 0, 5,  5,  0, 1, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 0,  11, 1, 5, 1, 0};
    tbl[10] = '{1, 0, 1, 0, 0,  23, 1, 5, 1, 0};
    tbl[11] = '{0, 0, 0, 1, 0,  23, 0, 5, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 0,  23, 0, 5, 0, 0};
    for (int i = 0; i < 13; i++) begin
      en = tbl[i].en; load = tbl[i].load; req = tbl[i].req; ack = tbl[i].ack;
      seed_in = W'(tbl[i].seed);
      @(posedge clk);
      model_step();
      #1;
      check($sformatf("tbl%0d.state", i), state_out, tbl[i].st);
      check($sformatf("tbl%0d.valid", i), valid, tbl[i].vld);
      check($sformatf("tbl%0d.num", i), num, tbl[i].nm);
      check($sformatf("tbl%0d.busy", i), busy, tbl[i].bsy);
      check($sformatf("tbl%0d.err", i), err, tbl[i].er);
    end
    idle_inputs();

    // full period from reset with en=1
    do_reset("rst_seq");
    exp_start = '{1, 3, 7, 15, 31, 62};
    foreach (seen[k]) seen[k] = 0;
    seen[0] = 1;
    distinct = 1;
    first_zero = -1;
    en = 1;
    for (int i = 1; i <= 63; i++) begin
      tick("seq");
      if (i <= 6) check($sformatf("seq_start%0d", i), state_out, exp_start[i-1]);
      if (state_out == 0 && first_zero < 0) first_zero = i;
      if (!seen[state_out]) begin seen[state_out] = 1; distinct++; end
    end
    check("seq_period", first_zero, 63);
    check("seq_distinct", distinct, 63);
    idle_inputs();

    // lockup behaviour on advance from all-ones
    do_reset("rst_lock");
    load = 1; seed_in = 6'd63;
    tick("lock_load");
    load = 0; en = 1;
    tick("lock_adv");
    check("lock_state", state_out, RECOVER ? 0 : 63);
    check("lock_flag", lockup_seen, RECOVER ? 1 : 0);
    for (int i = 0; i < 3; i++) tick("lock_hold");
    check("lock_sticky", lockup_seen, RECOVER ? 1 : 0);
    idle_inputs();
    do_reset("lock_clear");

    // reset in the middle of a long draw, then a fresh draw
    load = 1; seed_in = 6'd63;
    tick("mid_load");
    load = 0; req = 1;
    tick("mid_req");
    req = 0;
    for (int i = 0; i < 2; i++) tick("mid_draw");
    do_reset("mid_reset");
    req = 1;
    tick("post_req");
    req = 0;
    tick("post_rej");
    tick("post_acc");
    check("post_valid", valid, 1);
    check("post_num", num, 1);
    ack = 1;
    tick("post_ack");
    ack = 0;
    check("post_busy", busy, 0);

    // attempt limit from the all-ones seed
    do_reset("rst_limit");
    load = 1; seed_in = 6'd63;
    tick("lim_load");
    load = 0; req = 1;
    tick("lim_req");
    req = 0;
    cycles = 0;
    while (valid !== 1'b1 && cycles < 200) begin
      tick("lim_draw");
      cycles++;
    end
    check("lim_cycles", cycles, RECOVER ? 3 : 65);
    check("lim_valid", valid, 1);
    check("lim_num", num, 1);
    check("lim_err", err, RECOVER ? 0 : 1);
    ack = 1;
    tick("lim_ack");
    idle_inputs();

    // randomized traffic against the reference model
    do_reset("rst_rnd");
    for (int i = 0; i < 1500; i++) begin
      en   = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 15) == 0);
      seed_in = ($urandom_range(0, 3) == 0) ? 6'd63 : W'($urandom_range(0, 63));
      req  = ($urandom_range(0, 2) == 0);
      ack  = 1'($urandom_range(0, 1));
      tick("rnd");
      if ($urandom_range(0, 299) == 0) do_reset("rnd_reset");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
